// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event block.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int REPEAT_CNT_W = 8;
    localparam logic [REPEAT_CNT_W-1:0] REPEAT_CNT_MAX = '1;

    // Repeat counter sticks at its maximum instead of wrapping.
    function automatic logic [REPEAT_CNT_W-1:0] sat_inc(input logic [REPEAT_CNT_W-1:0] v);
        return (v == REPEAT_CNT_MAX) ? v : v + REPEAT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/key_event_if.sv
// Debounced-key in, event pulses out; master is the debouncer side.
interface key_event_if;
    import key_event_pkg::*;

    logic                    tick;
    logic                    key_level;
    logic                    press_pulse;
    logic                    release_pulse;
    logic                    repeat_pulse;
    logic                    held;
    logic [REPEAT_CNT_W-1:0] repeat_cnt;

    modport master (
        output tick, key_level,
        input  press_pulse, release_pulse, repeat_pulse, held, repeat_cnt
    );

    modport slave (
        input  tick, key_level,
        output press_pulse, release_pulse, repeat_pulse, held, repeat_cnt
    );

endinterface

// File: rtl/key_event_tick_counter.sv
// Tick-enabled counter that wraps to zero on reaching a selectable terminal value.
module tick_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;
    logic             at_term;

    assign at_term = (cnt == term);
    // hit marks the tick that completes the interval; clear masks it.
    assign hit     = en & at_term & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= at_term ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/key_event.sv
// Turns a debounced key level into press/release pulses plus typematic repeat.
module key_event
    import key_event_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int DELAY_TICKS = 500,
    parameter int RATE_TICKS  = 100
) (
    input logic        clk,
    input logic        reset,
    key_event_if.slave kif
);

    localparam logic [CNT_W-1:0] DLY_TERM  = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_TERM = CNT_W'(RATE_TICKS - 1);

    state_t           state;
    logic             key_q;
    logic             rise;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_hit;
    logic [CNT_W-1:0] term;

    assign rise    = kif.key_level & ~key_q;
    // Counter is held at zero while idle, so a press always starts a fresh interval.
    assign cnt_clr = (state == ST_IDLE);
    assign cnt_en  = kif.tick & kif.key_level;
    assign term    = (state == ST_HOLD) ? DLY_TERM : RATE_TERM;

    tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (term),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            key_q             <= 1'b0;
            kif.press_pulse   <= 1'b0;
            kif.release_pulse <= 1'b0;
            kif.repeat_pulse  <= 1'b0;
            kif.held          <= 1'b0;
            kif.repeat_cnt    <= '0;
        end else begin
            key_q             <= kif.key_level;
            kif.press_pulse   <= 1'b0;
            kif.release_pulse <= 1'b0;
            kif.repeat_pulse  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        kif.press_pulse <= 1'b1;
                        kif.repeat_cnt  <= '0;
                        kif.held        <= 1'b1;
                        state           <= ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    // Release outranks a coincident terminal tick.
                    if (!kif.key_level) begin
                        kif.release_pulse <= 1'b1;
                        kif.held          <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (cnt_hit) begin
                        kif.repeat_pulse <= 1'b1;
                        kif.repeat_cnt   <= sat_inc(kif.repeat_cnt);
                        state            <= ST_REPEAT;
                    end
                end
                default: begin
                    kif.held <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
